// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fpu_pkg
// Description : Shared constants, types and helpers for the single-precision
//               add/sub back end (normalize / round / pack).
//               Contents:
//                 RM_*        rounding-mode encodings as carried in FCSR
//                 QNAN        canonical quiet NaN
//                 EXP_MAX     all-ones biased exponent
//                 field widths for the raw sum, normalized fraction and
//                 the widened exponent used inside the pipeline
//                 special_e   special-result tag carried down the pipe
//                 norm_t      stage-1 payload
//                 ovf_word    packed result for an overflowed value
// Revision    : 1.0 - initial release
// ============================================================================
package fpu_pkg;

    localparam logic [1:0]  RM_RN   = 2'b00;  // round to nearest, ties to even
    localparam logic [1:0]  RM_RZ   = 2'b01;  // round toward zero
    localparam logic [1:0]  RM_RP   = 2'b10;  // round toward +inf
    localparam logic [1:0]  RM_RM   = 2'b11;  // round toward -inf

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [7:0]  EXP_MAX = 8'hFF;

    localparam int FRAC_W = 23;               // stored fraction
    localparam int EXP_W  = 8;                // biased exponent
    localparam int CAL_W  = 28;               // {carry, hidden, frac, G, R, S}
    localparam int NORM_W = 27;               // {hidden, frac, G, R, S}
    localparam int EXPX_W = 9;                // exponent with room for overflow
    localparam int LZ_W   = 5;                // leading-zero count of NORM_W bits

    typedef enum logic [1:0] {
        SPC_NONE = 2'd0,
        SPC_NAN  = 2'd1,
        SPC_INF  = 2'd2
    } special_e;

    typedef struct packed {
        logic [NORM_W-1:0] frac;
        logic [EXPX_W-1:0] exp;
        logic              sign;
        logic [1:0]        rm;
        special_e          spc;
    } norm_t;

    // Overflow goes to infinity only when the rounding direction points away
    // from zero for this sign; otherwise it saturates at the largest finite.
    function automatic logic [31:0] ovf_word(input logic sgn, input logic [1:0] rmode);
        logic to_inf;
        to_inf = (rmode == RM_RN)
               | ((rmode == RM_RP) & ~sgn)
               | ((rmode == RM_RM) &  sgn);
        return to_inf ? {sgn, EXP_MAX, 23'h0}
                      : {sgn, EXP_MAX - 8'd1, 23'h7F_FFFF};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fadd_lzc27.sv
`default_nettype none
// ============================================================================
// Module      : fadd_lzc27
// Description : Combinational leading-zero counter for a 27-bit vector.
//               Returns 27 when the input is all zeros.
// Ports       : a   in  27  vector to scan (bit 26 is the most significant)
//               lz  out  5  number of zeros above the highest set bit
// Revision    : 1.0 - initial release
// ============================================================================
module fadd_lzc27
    import fpu_pkg::*;
(
    input  logic [NORM_W-1:0] a,
    output logic [LZ_W-1:0]   lz
);

    // Scan upward; the last hit is the most significant set bit.
    always_comb begin
        lz = LZ_W'(NORM_W);
        for (int i = 0; i < NORM_W; i++) begin
            if (a[i]) begin
                lz = LZ_W'(NORM_W - 1 - i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fadd_norm_pipe.sv
`default_nettype none
// ============================================================================
// Module      : fadd_norm_pipe
// Description : Back end of the FP add/sub datapath. Stage 1 normalizes the
//               28-bit raw sum (right shift on carry, left shift by leading
//               zeros limited by the exponent). Stage 2 rounds per FCSR mode
//               and packs the IEEE-754 single result into output registers.
//               Two-entry elastic pipeline with valid/ready on both sides.
// Ports       : clk        in   1   clock, rising edge
//               rst        in   1   synchronous active-high reset
//               in_valid   in   1   input item present
//               in_ready   out  1   input accepted when in_valid & in_ready
//               cal_frac   in  28   {carry, hidden, frac[22:0], G, R, S}
//               temp_exp   in   8   biased exponent of larger operand
//               sign       in   1   result sign
//               rm         in   2   rounding mode (RN/RZ/RP/RM)
//               is_nan     in   1   NaN result
//               is_inf     in   1   infinity result
//               out_valid  out  1   result present
//               out_ready  in   1   result consumed when out_valid & out_ready
//               s          out 32   packed result
//               flags      out  3   {overflow, underflow, inexact}
// Revision    : 1.0 - initial release
// ============================================================================
module fadd_norm_pipe
    import fpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CAL_W-1:0]  cal_frac,
    input  logic [EXP_W-1:0]  temp_exp,
    input  logic              sign,
    input  logic [1:0]        rm,
    input  logic              is_nan,
    input  logic              is_inf,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       s,
    output logic [2:0]        flags
);

    // ------------------------------------------------------------------
    // Pipeline state
    // ------------------------------------------------------------------
    logic        s1_valid_q, s1_valid_d;
    norm_t       s1_q,       s1_d;
    logic        s2_valid_q, s2_valid_d;
    logic [31:0] s_q,        s_d;
    logic [2:0]  flags_q,    flags_d;

    // ------------------------------------------------------------------
    // Handshake: stage 2 can take a new item when empty or draining this
    // cycle; stage 1 can take one when empty or moving into stage 2.
    // ------------------------------------------------------------------
    logic s2_free;
    logic accept;

    assign s2_free  = ~s2_valid_q | out_ready;
    assign in_ready = ~s1_valid_q | s2_free;
    assign accept   = in_valid & in_ready;

    // ------------------------------------------------------------------
    // Stage 1: normalize
    // ------------------------------------------------------------------
    logic [LZ_W-1:0]   lz;
    logic [EXP_W-1:0]  shift_lim;
    logic [LZ_W-1:0]   shamt;
    logic [NORM_W-1:0] frac_shl;
    norm_t             norm;

    fadd_lzc27 u_lzc (
        .a  (cal_frac[NORM_W-1:0]),
        .lz (lz)
    );

    always_comb begin
        // The left shift stops at exponent 1 so a value that cannot reach
        // a set hidden bit lands as a denormal instead of wrapping.
        shift_lim = (temp_exp == '0) ? '0 : temp_exp - 8'd1;
        shamt     = ({3'b000, lz} < shift_lim) ? lz : shift_lim[LZ_W-1:0];
        frac_shl  = cal_frac[NORM_W-1:0] << shamt;

        norm      = '0;
        norm.sign = sign;
        norm.rm   = rm;
        if (is_nan) begin
            norm.spc = SPC_NAN;
        end else if (is_inf) begin
            norm.spc = SPC_INF;
        end else begin
            norm.spc = SPC_NONE;
        end

        if (cal_frac[CAL_W-1]) begin
            // Carry out: drop one bit, folding it into sticky.
            norm.frac = {cal_frac[CAL_W-1:2], cal_frac[1] | cal_frac[0]};
            norm.exp  = {1'b0, temp_exp} + 9'd1;
        end else if (cal_frac == '0) begin
            norm.frac = '0;
            norm.exp  = '0;
        end else begin
            norm.frac = frac_shl;
            norm.exp  = {1'b0, temp_exp} - {4'b0000, shamt};
            if (!frac_shl[NORM_W-1]) begin
                norm.exp = '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: round and pack (combinational from the stage-1 register)
    // ------------------------------------------------------------------
    logic              inexact;
    logic              round_up;
    logic [24:0]       rounded;
    logic [EXPX_W-1:0] exp_rnd;
    logic [FRAC_W-1:0] frac_rnd;
    logic [31:0]       res_word;
    logic [2:0]        res_flags;

    always_comb begin
        inexact = |s1_q.frac[2:0];

        unique case (s1_q.rm)
            RM_RN:   round_up = s1_q.frac[2] & (s1_q.frac[1] | s1_q.frac[0] | s1_q.frac[3]);
            RM_RZ:   round_up = 1'b0;
            RM_RP:   round_up = ~s1_q.sign & inexact;
            default: round_up =  s1_q.sign & inexact;
        endcase

        rounded = {1'b0, s1_q.frac[NORM_W-1:3]} + {24'h0, round_up};

        exp_rnd = s1_q.exp;
        if (rounded[24]) begin
            // Mantissa overflowed to 2.0: renormalize by one.
            exp_rnd  = s1_q.exp + 9'd1;
            frac_rnd = rounded[23:1];
        end else begin
            frac_rnd = rounded[22:0];
            // Denormal that rounded up into the hidden bit becomes normal.
            if ((s1_q.exp == '0) && rounded[23]) begin
                exp_rnd = 9'd1;
            end
        end

        if (s1_q.spc == SPC_NAN) begin
            res_word  = QNAN;
            res_flags = 3'b000;
        end else if (s1_q.spc == SPC_INF) begin
            res_word  = {s1_q.sign, EXP_MAX, 23'h0};
            res_flags = 3'b000;
        end else if (exp_rnd >= 9'd255) begin
            res_word  = ovf_word(s1_q.sign, s1_q.rm);
            res_flags = 3'b101;
        end else begin
            // A zero sum has exp 0 and no inexact bits, giving {sign,0}, flags 0.
            res_word  = {s1_q.sign, exp_rnd[EXP_W-1:0], frac_rnd};
            res_flags = {1'b0, inexact & (exp_rnd == '0), inexact};
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        s1_valid_d = accept | (s1_valid_q & ~s2_free);
        s1_d       = accept ? norm : s1_q;

        s2_valid_d = s2_free ? s1_valid_q : s2_valid_q;
        s_d        = s_q;
        flags_d    = flags_q;
        if (s2_free && s1_valid_q) begin
            s_d     = res_word;
            flags_d = res_flags;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_valid_q <= 1'b0;
            s_q        <= '0;
            flags_q    <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_q       <= s1_d;
            s2_valid_q <= s2_valid_d;
            s_q        <= s_d;
            flags_q    <= flags_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign s         = s_q;
    assign flags     = flags_q;

endmodule
`default_nettype wire

// File: tb/tb_fadd_norm_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_fadd_norm_pipe
// Description : Self-checking bench for fadd_norm_pipe. Directed vector
//               table, backpressure and reset sequences, then randomized
//               traffic scored against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fadd_norm_pipe;

    localparam int CLK_HALF = 5;

    typedef struct {
        logic [31:0] s;
        logic [2:0]  f;
    } exp_t;

    typedef struct {
        logic [27:0] cal;
        logic [7:0]  te;
        logic        sg;
        logic [1:0]  rm;
        logic        nan;
        logic        inf;
        logic [31:0] es;
        logic [2:0]  ef;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [27:0] cal_frac = '0;
    logic [7:0]  temp_exp = '0;
    logic        sign = 1'b0;
    logic [1:0]  rm = 2'b00;
    logic        is_nan = 1'b0;
    logic        is_inf = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] s;
    logic [2:0]  flags;

    int   n_vec = 0;
    int   n_err = 0;
    bit   rand_rdy = 1'b0;
    exp_t exp_q[$];

    always #CLK_HALF clk = ~clk;

    fadd_norm_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .cal_frac  (cal_frac),
        .temp_exp  (temp_exp),
        .sign      (sign),
        .rm        (rm),
        .is_nan    (is_nan),
        .is_inf    (is_inf),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .flags     (flags)
    );

    // ------------------------------------------------------------------
    // Reference model: value-level normalize / round / pack
    // ------------------------------------------------------------------
    function automatic exp_t model(input logic [27:0] cal, input logic [7:0] te,
                                   input logic sg, input logic [1:0] mode,
                                   input logic nan, input logic inf);
        exp_t   r;
        longint m, keep;
        int     e, rem;
        bit     up, inx, to_inf;
        if (nan) begin
            r.s = 32'h7FC0_0000; r.f = 3'b000; return r;
        end
        if (inf) begin
            r.s = {sg, 8'hFF, 23'h0}; r.f = 3'b000; return r;
        end
        if (cal == 28'h0) begin
            r.s = {sg, 31'h0}; r.f = 3'b000; return r;
        end
        m = longint'(cal);
        e = int'(te);
        if (m >= (64'd1 << 27)) begin
            m = (m >> 1) | (m & 1);
            e = e + 1;
        end else begin
            while (m < (64'd1 << 26) && e > 1) begin
                m = m * 2;
                e = e - 1;
            end
            if (m < (64'd1 << 26)) e = 0;
        end
        keep = m >> 3;
        rem  = int'(m & 7);
        inx  = (rem != 0);
        case (mode)
            2'b00:   up = (rem > 4) || (rem == 4 && keep[0]);
            2'b01:   up = 1'b0;
            2'b10:   up = !sg && inx;
            default: up = sg && inx;
        endcase
        keep = keep + (up ? 1 : 0);
        if (keep >= (64'd1 << 24)) begin
            keep = keep >> 1;
            e = e + 1;
        end else if (e == 0 && keep >= (64'd1 << 23)) begin
            e = 1;
        end
        if (e >= 255) begin
            to_inf = (mode == 2'b00) || (mode == 2'b10 && !sg) || (mode == 2'b11 && sg);
            r.s = to_inf ? {sg, 8'hFF, 23'h0} : {sg, 8'hFE, 23'h7F_FFFF};
            r.f = 3'b101;
        end else begin
            r.s = {sg, 8'(e), 23'(keep)};
            r.f = {1'b0, inx && (e == 0), inx};
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Check / drive helpers
    // ------------------------------------------------------------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // One clock: called at edge+1 with inputs set; scores handshakes at the edge.
    task automatic tick(input exp_t pend, output bit acc);
        exp_t e;
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
        #1;
        acc = in_valid && in_ready;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL unexpected_output: got %h, expected no item", s);
            end else begin
                e = exp_q.pop_front();
                check("result_s", s, e.s);
                check("result_flags", {29'h0, flags}, {29'h0, e.f});
            end
        end
        if (acc) exp_q.push_back(pend);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [27:0] c, input logic [7:0] te, input logic sg,
                        input logic [1:0] mode, input logic nn, input logic nf, input exp_t e);
        bit acc;
        int guard;
        guard = 0;
        cal_frac = c; temp_exp = te; sign = sg; rm = mode; is_nan = nn; is_inf = nf;
        in_valid = 1'b1;
        do begin
            tick(e, acc);
            guard++;
        end while (!acc && guard < 200);
        if (!acc) begin
            n_vec++; n_err++;
            $display("FAIL send_timeout: in_ready stuck low for %0d cycles", guard);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit   acc;
        exp_t dummy;
        int   guard;
        dummy.s = '0; dummy.f = '0;
        in_valid = 1'b0;
        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            tick(dummy, acc);
            guard++;
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout: %0d items outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    vec_t tbl[19];

    initial begin
        exp_t        e, dummy;
        bit          acc;
        int          n_acc;
        logic [31:0] held_s;
        logic [27:0] c;
        logic [7:0]  te;

        dummy.s = '0; dummy.f = '0;

        tbl[0]  = '{28'h8000000, 8'd127, 1'b0, 2'd0, 1'b0, 1'b0, 32'h40000000, 3'b000};
        tbl[1]  = '{28'h1000000, 8'd127, 1'b0, 2'd0, 1'b0, 1'b0, 32'h3E800000, 3'b000};
        tbl[2]  = '{28'h400000C, 8'd127, 1'b0, 2'd0, 1'b0, 1'b0, 32'h3F800002, 3'b001};
        tbl[3]  = '{28'h400000C, 8'd127, 1'b0, 2'd1, 1'b0, 1'b0, 32'h3F800001, 3'b001};
        tbl[4]  = '{28'h8000000, 8'd254, 1'b0, 2'd0, 1'b0, 1'b0, 32'h7F800000, 3'b101};
        tbl[5]  = '{28'h8000000, 8'd254, 1'b0, 2'd1, 1'b0, 1'b0, 32'h7F7FFFFF, 3'b101};
        tbl[6]  = '{28'h8000000, 8'd254, 1'b1, 2'd2, 1'b0, 1'b0, 32'hFF7FFFFF, 3'b101};
        tbl[7]  = '{28'h8000000, 8'd254, 1'b1, 2'd3, 1'b0, 1'b0, 32'hFF800000, 3'b101};
        tbl[8]  = '{28'h0000000, 8'd100, 1'b1, 2'd0, 1'b0, 1'b0, 32'h80000000, 3'b000};
        tbl[9]  = '{28'h0000123, 8'd90,  1'b1, 2'd0, 1'b1, 1'b1, 32'h7FC00000, 3'b000};
        tbl[10] = '{28'h0000123, 8'd90,  1'b1, 2'd0, 1'b0, 1'b1, 32'hFF800000, 3'b000};
        tbl[11] = '{28'h0000010, 8'd1,   1'b0, 2'd0, 1'b0, 1'b0, 32'h00000002, 3'b000};
        tbl[12] = '{28'h0000011, 8'd1,   1'b0, 2'd0, 1'b0, 1'b0, 32'h00000002, 3'b011};
        tbl[13] = '{28'h3FFFFFC, 8'd1,   1'b0, 2'd0, 1'b0, 1'b0, 32'h00800000, 3'b001};
        tbl[14] = '{28'h4000001, 8'd127, 1'b0, 2'd2, 1'b0, 1'b0, 32'h3F800001, 3'b001};
        tbl[15] = '{28'h4000001, 8'd127, 1'b0, 2'd3, 1'b0, 1'b0, 32'h3F800000, 3'b001};
        tbl[16] = '{28'h7FFFFFC, 8'd127, 1'b0, 2'd0, 1'b0, 1'b0, 32'h40000000, 3'b001};
        tbl[17] = '{28'h8000001, 8'd127, 1'b0, 2'd1, 1'b0, 1'b0, 32'h40000000, 3'b001};
        tbl[18] = '{28'h7FFFFFC, 8'd254, 1'b0, 2'd0, 1'b0, 1'b0, 32'h7F800000, 3'b101};

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_out_valid", {31'h0, out_valid}, 32'h0);
        check("reset_s", s, 32'h0);
        check("reset_flags", {29'h0, flags}, 32'h0);
        check("reset_in_ready", {31'h0, in_ready}, 32'h1);

        // Directed table, streamed back to back
        out_ready = 1'b1;
        for (int i = 0; i < 19; i++) begin
            e.s = tbl[i].es; e.f = tbl[i].ef;
            send(tbl[i].cal, tbl[i].te, tbl[i].sg, tbl[i].rm, tbl[i].nan, tbl[i].inf, e);
        end
        drain();

        // Backpressure: three items offered, only two fit
        out_ready = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 3; i++) begin
            cal_frac = 28'h4000000 | 28'(i << 3); temp_exp = 8'd120; sign = 1'b0;
            rm = 2'd1; is_nan = 1'b0; is_inf = 1'b0; in_valid = 1'b1;
            e = model(cal_frac, temp_exp, sign, rm, is_nan, is_inf);
            tick(e, acc);
            if (acc) n_acc++;
        end
        check("bp_accepted", 32'(n_acc), 32'd2);
        check("bp_in_ready", {31'h0, in_ready}, 32'h0);
        check("bp_out_valid", {31'h0, out_valid}, 32'h1);
        held_s = s;
        tick(dummy, acc);
        check("bp_hold_s", s, held_s);
        out_ready = 1'b1;
        e = model(cal_frac, temp_exp, sign, rm, is_nan, is_inf);
        send(cal_frac, temp_exp, sign, rm, is_nan, is_inf, e);
        drain();

        // Reset with two items in flight
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            e = model(28'h8000000, 8'd100, 1'b0, 2'd0, 1'b0, 1'b0);
            send(28'h8000000, 8'd100, 1'b0, 2'd0, 1'b0, 1'b0, e);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        check("rst_flush_out_valid", {31'h0, out_valid}, 32'h0);
        check("rst_flush_in_ready", {31'h0, in_ready}, 32'h1);
        out_ready = 1'b1;
        e.s = 32'h7FC00000; e.f = 3'b000;
        send(28'h0000000, 8'd1, 1'b1, 2'd2, 1'b1, 1'b0, e);
        drain();

        // Randomized traffic with random backpressure and input gaps
        rand_rdy = 1'b1;
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0:       c = 28'($urandom);
                1:       c = 28'($urandom) >> $urandom_range(0, 27);
                2:       c = 28'h8000000 | 28'($urandom);
                default: c = 28'($urandom) & 28'h7FFFFFF;
            endcase
            case ($urandom_range(0, 3))
                0:       te = 8'($urandom_range(1, 4));
                1:       te = 8'($urandom_range(250, 254));
                default: te = 8'($urandom_range(1, 254));
            endcase
            sign     = 1'($urandom);
            rm       = 2'($urandom);
            is_nan   = ($urandom_range(0, 15) == 0);
            is_inf   = ($urandom_range(0, 15) == 0);
            e = model(c, te, sign, rm, is_nan, is_inf);
            send(c, te, sign, rm, is_nan, is_inf, e);
            if ($urandom_range(0, 3) == 0) tick(dummy, acc);
        end
        rand_rdy  = 1'b0;
        out_ready = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
